// File: rtl/fader_coef_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fader_coef_pkg
// Description : Shared constants and types for the fader complex tap store.
//               NTAPS  - number of complex taps seen by the convolver
//               W      - tap component width (signed s1.16)
//               TAP0_RESET - real part of tap 0 after reset (1.0)
// Revision    : 1.0 - initial release
// ============================================================================
package fader_coef_pkg;

    localparam int NTAPS = 32;
    localparam int W     = 18;
    localparam int AW    = $clog2(NTAPS);

    localparam logic signed [W-1:0] TAP0_RESET = 18'sh10000;

    typedef logic signed [W-1:0] coef_t;
    typedef coef_t [NTAPS-1:0]   coef_bank_t;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } coef_state_t;

    // Real part of a unit-impulse (pass-through) filter.
    function automatic coef_bank_t unit_impulse_real();
        coef_bank_t b;
        b    = '0;
        b[0] = TAP0_RESET;
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fader_coef_bank.sv
`default_nettype none
// ============================================================================
// Module      : fader_coef_bank
// Description : Double-buffered complex tap store feeding the 32-tap complex
//               convolver. Taps are written one at a time into a shadow bank;
//               a commit request arms a swap that copies the entire shadow
//               bank into the active bank on the next sample-boundary strobe,
//               so the convolver never observes a half-updated tap set.
//
// Ports       : clk            - system clock
//               reset          - synchronous active-high reset
//               wr_en          - shadow tap write strobe
//               wr_addr        - shadow tap index
//               wr_real/imag   - tap components to write
//               wr_ready       - writes accepted (IDLE)
//               commit         - request to publish the shadow bank
//               swap_strobe    - sample-boundary tick; swaps happen only here
//               commit_pending - commit armed, swap not yet done
//               wr_drop        - sticky: a write was refused while busy
//               coef_real/imag - active taps to the convolver
//               swap_count     - completed swaps, wraps modulo 2^CNT_W
// Revision    : 1.0 - initial release
// ============================================================================
module fader_coef_bank
    import fader_coef_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wr_en,
    input  logic [AW-1:0]               wr_addr,
    input  logic [W-1:0]                wr_real,
    input  logic [W-1:0]                wr_imag,
    output logic                        wr_ready,
    input  logic                        commit,
    input  logic                        swap_strobe,
    output logic                        commit_pending,
    output logic                        wr_drop,
    output logic [NTAPS-1:0][W-1:0]     coef_real,
    output logic [NTAPS-1:0][W-1:0]     coef_imag,
    output logic [CNT_W-1:0]            swap_count
);

    // One extra bit so the bound compare also works when NTAPS is not a
    // power of two and wr_addr can name a non-existent tap.
    localparam logic [AW:0] c_ntaps = (AW+1)'(NTAPS);

    coef_state_t     r_state;
    coef_state_t     w_state_next;

    coef_bank_t      r_shadow_real;
    coef_bank_t      r_shadow_imag;
    coef_bank_t      r_active_real;
    coef_bank_t      r_active_imag;

    logic            r_wr_drop;
    logic [CNT_W-1:0] r_swap_count;

    logic            w_addr_ok;
    logic            w_shadow_we;
    logic            w_swap;
    logic            w_drop_set;

    assign w_addr_ok = ({1'b0, wr_addr} < c_ntaps);

    // ------------------------------------------------------------------
    // Control FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM: next state and datapath strobes
    // A write in the commit cycle lands in the shadow on the same edge the
    // FSM arms, so it is part of the published set. A strobe coincident
    // with commit is seen while still IDLE and therefore does nothing.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_shadow_we  = 1'b0;
        w_swap       = 1'b0;
        w_drop_set   = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_shadow_we = wr_en && w_addr_ok;
                if (commit) begin
                    w_state_next = PENDING;
                end
            end
            PENDING: begin
                // Shadow is frozen until the swap; refused writes are flagged.
                w_drop_set = wr_en && w_addr_ok;
                if (swap_strobe) begin
                    w_swap       = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Shadow bank: single-tap writes, never cleared by a swap
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shadow_real <= unit_impulse_real();
            r_shadow_imag <= '0;
        end else if (w_shadow_we) begin
            r_shadow_real[wr_addr] <= wr_real;
            r_shadow_imag[wr_addr] <= wr_imag;
        end
    end

    // ------------------------------------------------------------------
    // Active bank: whole-bank copy on a single edge
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_active_real <= unit_impulse_real();
            r_active_imag <= '0;
        end else if (w_swap) begin
            r_active_real <= r_shadow_real;
            r_active_imag <= r_shadow_imag;
        end
    end

    // ------------------------------------------------------------------
    // Status: sticky drop flag and swap counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_drop    <= 1'b0;
            r_swap_count <= '0;
        end else begin
            if (w_drop_set) begin
                r_wr_drop <= 1'b1;
            end
            if (w_swap) begin
                r_swap_count <= r_swap_count + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: straight from registers (state decode only)
    // ------------------------------------------------------------------
    assign wr_ready       = (r_state == IDLE);
    assign commit_pending = (r_state == PENDING);
    assign wr_drop        = r_wr_drop;
    assign coef_real      = r_active_real;
    assign coef_imag      = r_active_imag;
    assign swap_count     = r_swap_count;

endmodule
`default_nettype wire

// File: tb/tb_fader_coef_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_fader_coef_bank
// Description : Self-checking bench for fader_coef_bank. A table of per-cycle
//               input/expected-output records drives the main scenarios; hand
//               sequences cover reset during a pending commit and counter
//               wrap (a second instance with a 4-bit counter shares inputs).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fader_coef_bank;

    logic                clk;
    logic                reset;
    logic                wr_en;
    logic [4:0]          wr_addr;
    logic [17:0]         wr_real;
    logic [17:0]         wr_imag;
    logic                commit;
    logic                swap_strobe;

    logic                wr_ready;
    logic                commit_pending;
    logic                wr_drop;
    logic [31:0][17:0]   coef_real;
    logic [31:0][17:0]   coef_imag;
    logic [15:0]         swap_count;

    logic                s_wr_ready;
    logic                s_commit_pending;
    logic                s_wr_drop;
    logic [31:0][17:0]   s_coef_real;
    logic [31:0][17:0]   s_coef_imag;
    logic [3:0]          s_swap_count;

    int total;
    int bad;
    int exp_cnt;

    fader_coef_bank u_dut (
        .clk            (clk),
        .reset          (reset),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_real        (wr_real),
        .wr_imag        (wr_imag),
        .wr_ready       (wr_ready),
        .commit         (commit),
        .swap_strobe    (swap_strobe),
        .commit_pending (commit_pending),
        .wr_drop        (wr_drop),
        .coef_real      (coef_real),
        .coef_imag      (coef_imag),
        .swap_count     (swap_count)
    );

    fader_coef_bank #(.CNT_W(4)) u_dut_small (
        .clk            (clk),
        .reset          (reset),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_real        (wr_real),
        .wr_imag        (wr_imag),
        .wr_ready       (s_wr_ready),
        .commit         (commit),
        .swap_strobe    (swap_strobe),
        .commit_pending (s_commit_pending),
        .wr_drop        (s_wr_drop),
        .coef_real      (s_coef_real),
        .coef_imag      (s_coef_imag),
        .swap_count     (s_swap_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [17:0] re;
        logic [17:0] im;
        logic        cm;
        logic        st;
        logic        e_rdy;
        logic        e_pend;
        logic        e_drop;
        logic [15:0] e_cnt;
        logic [4:0]  p_addr;
        logic [17:0] p_re;
        logic [17:0] p_im;
    } vec_t;

    vec_t vt[24];
    int   nv;

    function automatic vec_t mk(input logic we, input logic [4:0] addr,
                                input logic [17:0] re, input logic [17:0] im,
                                input logic cm, input logic st,
                                input logic e_rdy, input logic e_pend,
                                input logic e_drop, input logic [15:0] e_cnt,
                                input logic [4:0] p_addr,
                                input logic [17:0] p_re, input logic [17:0] p_im);
        vec_t v;
        v.we = we; v.addr = addr; v.re = re; v.im = im; v.cm = cm; v.st = st;
        v.e_rdy = e_rdy; v.e_pend = e_pend; v.e_drop = e_drop; v.e_cnt = e_cnt;
        v.p_addr = p_addr; v.p_re = p_re; v.p_im = p_im;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Active bank must equal the unit-impulse pattern on every tap.
    task automatic chk_rst_bank(input string nm);
        logic [31:0][17:0] er;
        logic [31:0][17:0] ei;
        er    = '0;
        er[0] = 18'h10000;
        ei    = '0;
        total++;
        if (coef_real !== er || coef_imag !== ei) begin
            bad++;
            $display("FAIL %s actual_real0=%h actual_real1=%h actual_imag0=%h required=unit impulse",
                     nm, coef_real[0], coef_real[1], coef_imag[0]);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] addr, input logic [17:0] re,
                         input logic [17:0] im, input logic cm, input logic st);
        @(negedge clk);
        wr_en = we; wr_addr = addr; wr_real = re; wr_imag = im;
        commit = cm; swap_strobe = st;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        drive(1'b0, 5'd0, 18'h0, 18'h0, 1'b0, 1'b0);
    endtask

    initial begin
        total = 0; bad = 0; exp_cnt = 0;
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_real = '0; wr_imag = '0;
        commit = 1'b0; swap_strobe = 1'b0;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk_rst_bank("reset_bank");
        chk("reset_rdy",  32'(wr_ready), 32'd1);
        chk("reset_pend", 32'(commit_pending), 32'd0);
        chk("reset_drop", 32'(wr_drop), 32'd0);
        chk("reset_cnt",  32'(swap_count), 32'd0);

        // ---------------- table-driven scenarios ----------------
        nv = 0;
        //              we addr re        im        cm st   rdy pend drop cnt  probe
        vt[nv++] = mk(1, 5,  18'h00123, 18'h3FF00, 0, 0,  1, 0, 0, 16'd0, 5,  18'h0,     18'h0);
        vt[nv++] = mk(1, 31, 18'h20000, 18'h00001, 0, 0,  1, 0, 0, 16'd0, 31, 18'h0,     18'h0);
        vt[nv++] = mk(0, 0,  18'h0,     18'h0,     1, 0,  0, 1, 0, 16'd0, 0,  18'h10000, 18'h0);
        vt[nv++] = mk(0, 0,  18'h0,     18'h0,     0, 0,  0, 1, 0, 16'd0, 5,  18'h0,     18'h0);
        vt[nv++] = mk(0, 0,  18'h0,     18'h0,     0, 0,  0, 1, 0, 16'd0, 31, 18'h0,     18'h0);
        vt[nv++] = mk(0, 0,  18'h0,     18'h0,     0, 0,  0, 1, 0, 16'd0, 5,  18'h0,     18'h0);
        vt[nv++] = mk(0, 0,  18'h0,     18'h0,     0, 1,  1, 0, 0, 16'd1, 5,  18'h00123, 18'h3FF00);
        vt[nv++] = mk(0, 0,  18'h0,     18'h0,     0, 0,  1, 0, 0, 16'd1, 31, 18'h20000, 18'h00001);
        vt[nv++] = mk(0, 0,  18'h0,     18'h0,     0, 0,  1, 0, 0, 16'd1, 0,  18'h10000, 18'h0);
        // commit and strobe together: strobe must not swap
        vt[nv++] = mk(1, 5,  18'h00456, 18'h00789, 0, 0,  1, 0, 0, 16'd1, 5,  18'h00123, 18'h3FF00);
        vt[nv++] = mk(0, 0,  18'h0,     18'h0,     1, 1,  0, 1, 0, 16'd1, 5,  18'h00123, 18'h3FF00);
        vt[nv++] = mk(0, 0,  18'h0,     18'h0,     0, 0,  0, 1, 0, 16'd1, 5,  18'h00123, 18'h3FF00);
        vt[nv++] = mk(0, 0,  18'h0,     18'h0,     1, 0,  0, 1, 0, 16'd1, 5,  18'h00123, 18'h3FF00);
        vt[nv++] = mk(0, 0,  18'h0,     18'h0,     0, 0,  0, 1, 0, 16'd1, 5,  18'h00123, 18'h3FF00);
        vt[nv++] = mk(0, 0,  18'h0,     18'h0,     0, 1,  1, 0, 0, 16'd2, 5,  18'h00456, 18'h00789);
        // write while pending: dropped and flagged
        vt[nv++] = mk(0, 0,  18'h0,     18'h0,     1, 0,  0, 1, 0, 16'd2, 3,  18'h0,     18'h0);
        vt[nv++] = mk(1, 3,  18'h0AAAA, 18'h15555, 0, 0,  0, 1, 1, 16'd2, 3,  18'h0,     18'h0);
        vt[nv++] = mk(0, 0,  18'h0,     18'h0,     0, 1,  1, 0, 1, 16'd3, 3,  18'h0,     18'h0);
        vt[nv++] = mk(1, 9,  18'h3FFFF, 18'h20001, 0, 0,  1, 0, 1, 16'd3, 9,  18'h0,     18'h0);
        // write in the commit cycle is part of the commit
        vt[nv++] = mk(1, 7,  18'h1FFFF, 18'h20000, 1, 0,  0, 1, 1, 16'd3, 7,  18'h0,     18'h0);
        vt[nv++] = mk(0, 0,  18'h0,     18'h0,     0, 1,  1, 0, 1, 16'd4, 7,  18'h1FFFF, 18'h20000);
        vt[nv++] = mk(0, 0,  18'h0,     18'h0,     0, 0,  1, 0, 1, 16'd4, 9,  18'h3FFFF, 18'h20001);
        vt[nv++] = mk(0, 0,  18'h0,     18'h0,     0, 0,  1, 0, 1, 16'd4, 3,  18'h0,     18'h0);
        vt[nv++] = mk(0, 0,  18'h0,     18'h0,     0, 0,  1, 0, 1, 16'd4, 5,  18'h00456, 18'h00789);

        for (int i = 0; i < nv; i++) begin
            drive(vt[i].we, vt[i].addr, vt[i].re, vt[i].im, vt[i].cm, vt[i].st);
            chk($sformatf("row%0d_rdy", i),  32'(wr_ready),       32'(vt[i].e_rdy));
            chk($sformatf("row%0d_pend", i), 32'(commit_pending), 32'(vt[i].e_pend));
            chk($sformatf("row%0d_drop", i), 32'(wr_drop),        32'(vt[i].e_drop));
            chk($sformatf("row%0d_cnt", i),  32'(swap_count),     32'(vt[i].e_cnt));
            chk($sformatf("row%0d_scnt", i), 32'(s_swap_count),   32'(vt[i].e_cnt[3:0]));
            chk($sformatf("row%0d_re", i),   32'(coef_real[vt[i].p_addr]), 32'(vt[i].p_re));
            chk($sformatf("row%0d_im", i),   32'(coef_imag[vt[i].p_addr]), 32'(vt[i].p_im));
        end

        // ---------------- reset abandons a pending commit ----------------
        drive(1'b1, 5'd5, 18'h3FFFF, 18'h3FFFF, 1'b1, 1'b0);
        chk("rstp_armed", 32'(commit_pending), 32'd1);
        @(negedge clk);
        wr_en = 1'b0; commit = 1'b0; reset = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b0;
        chk("rstp_pend", 32'(commit_pending), 32'd0);
        chk("rstp_rdy",  32'(wr_ready), 32'd1);
        chk("rstp_drop", 32'(wr_drop), 32'd0);
        chk("rstp_cnt",  32'(swap_count), 32'd0);
        drive(1'b0, 5'd0, 18'h0, 18'h0, 1'b0, 1'b1);
        chk("rstp_nostrobe_cnt", 32'(swap_count), 32'd0);
        chk_rst_bank("rstp_nostrobe_bank");
        // shadow was reset too: publishing it yields the unit impulse
        drive(1'b0, 5'd0, 18'h0, 18'h0, 1'b1, 1'b0);
        drive(1'b0, 5'd0, 18'h0, 18'h0, 1'b0, 1'b1);
        chk("rstp_republish_cnt", 32'(swap_count), 32'd1);
        chk_rst_bank("rstp_republish_bank");
        idle_cycle();

        // ---------------- counter wrap (4-bit instance) ----------------
        exp_cnt = 1;
        for (int k = 0; k < 15; k++) begin
            drive(1'b0, 5'd0, 18'h0, 18'h0, 1'b1, 1'b0);
            drive(1'b0, 5'd0, 18'h0, 18'h0, 1'b0, 1'b1);
            exp_cnt++;
            chk($sformatf("wrap%0d_cnt", k),  32'(swap_count),   32'(exp_cnt % 65536));
            chk($sformatf("wrap%0d_scnt", k), 32'(s_swap_count), 32'(exp_cnt % 16));
        end
        chk("wrap_small_zero", 32'(s_swap_count), 32'd0);
        chk("wrap_main_16",    32'(swap_count),   32'd16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fader_coef_bank.md
Name: fader_coef_bank

Overview:
- Double-buffered complex tap store that drives the 32-tap complex convolver's coef_real/coef_imag array ports in the fader datapath.
- Software/sequencer writes taps one at a time into a shadow bank, then requests a commit.
- The whole active bank is replaced atomically on the next sample-boundary strobe, so the convolver never sees a half-updated tap set.
- Reset loads a pass-through (unit impulse) filter.

Parameters:
- NTAPS, 32, number of complex taps (matches convolver).
- W, 18, tap component width, signed s1.16.
- TAP0_RESET, 18'sh10000, reset value of real part of tap 0 (1.0); all other reset components 0.
- CNT_W, 16, width of swap_count.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  write strobe for one shadow tap.
- wr_addr  in  $clog2(NTAPS)  shadow tap index.
- wr_real  in  W  real component to write.
- wr_imag  in  W  imaginary component to write.
- wr_ready  out  1  high when writes are accepted (state IDLE).
- commit  in  1  single-cycle request to publish the shadow bank.
- swap_strobe  in  1  sample-boundary tick; swap is only allowed here.
- commit_pending  out  1  commit accepted, swap not yet done.
- wr_drop  out  1  sticky: a write arrived while wr_ready=0.
- coef_real  out  [NTAPS-1:0][W-1:0]  active real taps, to convolver.
- coef_imag  out  [NTAPS-1:0][W-1:0]  active imaginary taps, to convolver.
- swap_count  out  CNT_W  number of completed swaps, wraps modulo 2^CNT_W.

Behaviour:
- Reset (synchronous, one cycle) sets:
  - both banks: tap0 = (TAP0_RESET, 0), all other taps (0, 0);
  - state IDLE, wr_ready=1, commit_pending=0, wr_drop=0, swap_count=0.
- Reset asserted mid-PENDING abandons the commit and forces all of the above.
- FSM, state IDLE:
  - wr_ready=1.
  - wr_en writes shadow[wr_addr] on the clock edge.
  - commit moves to PENDING next cycle. A write in the same cycle as commit is accepted and is part of the commit.
  - swap_strobe alone has no effect.
- FSM, state PENDING:
  - wr_ready=0, commit_pending=1.
  - wr_en is ignored, shadow is unchanged, and wr_drop is set (sticky until reset).
  - commit is ignored.
  - On the first swap_strobe in PENDING: active <= shadow (all 2*NTAPS components on the same edge), swap_count++, next state IDLE.
- A swap_strobe in the same cycle as commit (IDLE) does not trigger the swap; a later strobe is required.
- Latency:
  - coef_* change on the clock edge at which swap_strobe is sampled in PENDING, i.e. visible in the cycle after the strobe.
  - commit_pending falls on that same edge and wr_ready rises on it.
  - Minimum commit-to-update is 2 cycles.
- Shadow is not cleared by a swap; partial rewrites after a swap modify only the addressed taps.
- wr_addr values >= NTAPS (possible only if NTAPS is not a power of 2) are ignored and do not set wr_drop.
- All outputs are registered; no combinational path from inputs to coef_*.
- Values are stored verbatim; there is no arithmetic, saturation or sign manipulation.

Decomposition:
- Shared package fader_coef_pkg:
  - NTAPS, W, TAP0_RESET constants;
  - typedef logic signed [W-1:0] coef_t;
  - typedef coef_t [NTAPS-1:0] coef_bank_t;
  - enum {IDLE, PENDING} coef_state_t.
- Single module; the two banks are plain register arrays. No sub-module is warranted.

Test Plan:
- Reset release, no stimulus -> coef_real[0]=18'h10000, all other coef_real/coef_imag=0, wr_ready=1, commit_pending=0, swap_count=0.
- Write tap5=(18'h00123, 18'h3FF00) and tap31=(18'h20000, 18'h00001); commit; strobe 10 cycles later -> coef_* unchanged until the strobe edge; then tap5/tap31 take the new values, tap0=(0x10000, 0) retained, swap_count=1, wr_ready=1.
- commit and swap_strobe in the same cycle, next strobe 4 cycles later -> no swap on the first strobe, commit_pending=1 for those cycles, swap on the second strobe, swap_count=1.
- wr_en to tap3 while PENDING -> write not applied (tap3 unchanged after swap), wr_drop=1 and stays 1 through the swap and later IDLE writes.
- Write tap7 together with commit in the same cycle, then strobe -> tap7 new value appears in the active bank.
- Commit, then assert reset for 1 cycle before any strobe, then strobe -> no swap, state IDLE, coef at reset pattern, swap_count=0. Separately, 65536 commit/strobe pairs -> swap_count wraps to 0.
